instruction_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the instruction memory write port. Consumes bytes from the UART receiver, frames them with a small header and optional checksum, assembles 32-bit words and issues one-cycle word writes into instruction memory. Holds the core stalled while a load is in progress and reports completion or error.

---
 rtl/instruction_loader.sv | 197 +++++++++++++++++++
 tb/tb_instruction_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// instruction_loader
// Byte-stream program loader feeding the instruction memory write port.
// Frame: START_BYTE, LEN_LO, LEN_HI (word count N, little-endian), N*4 data
// bytes, then an optional XOR checksum byte. Every completed 32-bit word is
// written with a one-cycle strobe, and the core is stalled while loading.
// Optional feature: define LOADER_CHECKSUM_EN to require and verify the
// trailing checksum byte (CHECK state and XOR accumulator).
module instruction_loader #(
  parameter int         MAX_WORDS      = 256,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] START_BYTE     = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] mem_byte_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK  = 3'd4;
`endif
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam int                IDLE_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]       MAX_WORDS_16 = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  // Running checksum is a plain XOR over every data byte.
  function automatic logic [7:0] checksum_update(input logic [7:0] sum,
                                                  input logic [7:0] data);
    return sum ^ data;
  endfunction

  logic [7:0]  csum_r;
`endif

  logic [2:0]        state_r;
  logic [7:0]        len_lo_r;
  logic [15:0]       len_r;
  logic [15:0]       word_cnt_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic              in_frame_s;
  logic              timeout_s;
  logic [15:0]       len_s;
  logic              last_word_s;

  assign len_s       = {rx_data, len_lo_r};
  assign last_word_s = ((word_cnt_r + 16'd1) == len_r);
  assign timeout_s   = in_frame_s && !rx_valid && (idle_cnt_r == IDLE_LAST);

  // Decode the states in which a frame is open and the inter-byte timeout runs
  always_comb begin
    in_frame_s = 1'b0;
    case (state_r)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: in_frame_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK:                      in_frame_s = 1'b1;
`endif
      default:                       in_frame_s = 1'b0;
    endcase
  end

  // Count idle cycles between bytes while a frame is open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else if (in_frame_s && !rx_valid) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end
  end

  // Frame sequencer: header parsing, word assembly, memory writes and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      len_lo_r         <= 8'd0;
      len_r            <= 16'd0;
      word_cnt_r       <= 16'd0;
      byte_cnt_r       <= 2'd0;
      asm_r            <= 24'd0;
      mem_byte_address <= 32'd0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= 32'd0;
      cpu_stall        <= 1'b0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_r           <= 8'd0;
`endif
    end else begin
      mem_write_enable <= 1'b0;
      if (timeout_s) begin
        // A stalled sender abandons the frame; any partial word is dropped.
        state_r    <= ST_ERROR;
        load_error <= 1'b1;
        cpu_stall  <= 1'b1;
      end else if (rx_valid) begin
        case (state_r)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (rx_data == START_BYTE) begin
              state_r          <= ST_LEN_LO;
              load_done        <= 1'b0;
              load_error       <= 1'b0;
              cpu_stall        <= 1'b1;
              word_cnt_r       <= 16'd0;
              byte_cnt_r       <= 2'd0;
              mem_byte_address <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
              csum_r           <= 8'd0;
`endif
            end
          end
          ST_LEN_LO: begin
            len_lo_r <= rx_data;
            state_r  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len_r <= len_s;
            if (len_s > MAX_WORDS_16) begin
              state_r    <= ST_ERROR;
              load_error <= 1'b1;
            end else if (len_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_r   <= ST_CHECK;
`else
              state_r   <= ST_DONE;
              cpu_stall <= 1'b0;
              load_done <= 1'b1;
`endif
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            csum_r <= checksum_update(csum_r, rx_data);
`endif
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0:    asm_r[7:0]   <= rx_data;
              2'd1:    asm_r[15:8]  <= rx_data;
              2'd2:    asm_r[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word: issue the write now.
                mem_write_data   <= {rx_data, asm_r};
                mem_write_enable <= 1'b1;
                mem_byte_address <= {14'd0, word_cnt_r, 2'b00};
                word_cnt_r       <= word_cnt_r + 16'd1;
                if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                  state_r   <= ST_CHECK;
`else
                  state_r   <= ST_DONE;
                  cpu_stall <= 1'b0;
                  load_done <= 1'b1;
`endif
                end
              end
            endcase
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHECK: begin
            if (rx_data == csum_r) begin
              state_r   <= ST_DONE;
              cpu_stall <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_r    <= ST_ERROR;
              load_error <= 1'b1;
            end
          end
`endif
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a table of single-byte steps with
// expected outputs, plus hand-written sequences for reset, timeout, bad
// checksum, reset mid-frame and the largest accepted frame.
module tb_instruction_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] mem_byte_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        cpu_stall;
  logic        load_done;
  logic        load_error;

  instruction_loader #(
    .MAX_WORDS(256),
    .TIMEOUT_CYCLES(TO),
    .START_BYTE(8'h55)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .mem_byte_address(mem_byte_address),
    .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data),
    .cpu_stall(cpu_stall),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          failures = 0;
  int          wr_count = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  // Write monitor: strobe is one cycle wide, so the falling edge sees it once.
  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      wr_count   = wr_count + 1;
      last_addr  = mem_byte_address;
      last_wdata = mem_write_data;
    end
  end

  function automatic void add(input logic v, input logic [7:0] d, input logic we,
                              input logic [31:0] a, input logic [31:0] w,
                              input logic s, input logic dn, input logic e);
    vec_t r;
    r.valid = v; r.data = d; r.we = we; r.addr = a; r.wdata = w;
    r.stall = s; r.done = dn; r.err = e;
    vecs.push_back(r);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {13'd0, mem_write_enable, mem_byte_address, mem_write_data,
            cpu_stall, load_done, load_error};
  endfunction

  initial begin
    int wr_base;

    // Frame 1: two words, normal load (non-start byte in IDLE ignored first).
    add(1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h12, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h55, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h13, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b1, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h93, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h50, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    add(1'b1, 8'h00, 1'b1, 32'h4, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hD0, 1'b0, 32'h4, 32'h00500093, 1'b0, 1'b1, 1'b0);
`else
    add(1'b1, 8'h00, 1'b1, 32'h4, 32'h00500093, 1'b0, 1'b1, 1'b0);
`endif
    add(1'b0, 8'h00, 1'b0, 32'h4, 32'h00500093, 1'b0, 1'b1, 1'b0);
    // Frame 2: N=257 exceeds the limit.
    add(1'b1, 8'h55, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'h00, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b1);
    // Frame 3: restart from ERROR, START_BYTE value inside data.
    add(1'b1, 8'h55, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h55, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hAA, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h55, 1'b0, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    add(1'b1, 8'h00, 1'b1, 32'h0, 32'h0055AA55, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hAA, 1'b0, 32'h0, 32'h0055AA55, 1'b0, 1'b1, 1'b0);
`else
    add(1'b1, 8'h00, 1'b1, 32'h0, 32'h0055AA55, 1'b0, 1'b1, 1'b0);
`endif

    // Reset state and 1000 quiet cycles.
    idle(3);
    check("reset_outputs", outs(), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1000);
    check("quiet_outputs", outs(), 80'd0);
    check("quiet_writes", 80'(wr_count), 80'd0);

    // Table-driven byte steps.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].data);
      check($sformatf("vec%0d", i), outs(),
            {13'd0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].stall, vecs[i].done, vecs[i].err});
    end
    idle(1);
    check("table_writes", 80'(wr_count), 80'd3);

    // Timeout after a partial word, exact boundary.
    drive(1'b1, 8'h55); drive(1'b1, 8'h01); drive(1'b1, 8'h00);
    drive(1'b1, 8'h11); drive(1'b1, 8'h22);
    idle(TO - 1);
    check("timeout_not_yet", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b100});
    idle(1);
    check("timeout_error", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b101});
    idle(2);
    check("timeout_no_write", 80'(wr_count), 80'd3);

    // Empty frame recovers from the error.
    drive(1'b1, 8'h55); drive(1'b1, 8'h00); drive(1'b1, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h00);
`endif
    check("empty_frame_done", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b010});

    // One-word frame (bad checksum when enabled).
    drive(1'b1, 8'h55); drive(1'b1, 8'h01); drive(1'b1, 8'h00);
    drive(1'b1, 8'h01); drive(1'b1, 8'h02); drive(1'b1, 8'h03); drive(1'b1, 8'h04);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'hFF);
    check("bad_csum_status", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b101});
`else
    check("one_word_status", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b010});
`endif
    idle(1);
    check("one_word_writes", 80'(wr_count), 80'd4);
    check("one_word_data", {48'd0, last_wdata}, {48'd0, 32'h04030201});

    // Reset asserted mid-DATA.
    drive(1'b1, 8'h55); drive(1'b1, 8'h01); drive(1'b1, 8'h00);
    drive(1'b1, 8'hAA); drive(1'b1, 8'hBB);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", outs(), 80'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'hCC); drive(1'b1, 8'hDD);
    idle(3);
    check("mid_reset_no_write", 80'(wr_count), 80'd4);
    check("mid_reset_status", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b000});

    // Largest accepted frame: N=256, byte k carries k[7:0].
    wr_base = wr_count;
    drive(1'b1, 8'h55); drive(1'b1, 8'h00); drive(1'b1, 8'h01);
    for (int k = 0; k < 1024; k++) drive(1'b1, 8'(k));
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h00);
`endif
    idle(1);
    check("max_writes", 80'(wr_count - wr_base), 80'd256);
    check("max_last_addr", {48'd0, last_addr}, {48'd0, 32'h000003FC});
    check("max_last_data", {48'd0, last_wdata}, {48'd0, 32'hFFFEFDFC});
    check("max_status", {77'd0, cpu_stall, load_done, load_error}, {77'd0, 3'b010});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
